// File: rtl/cache_if.sv
// Request/response bundle between the L2 controller and the cache tag/state store.
// Valid-only handshake: req_valid marks a request in the cycle it is present (there is no ready
// and no backpressure); resp_valid pulses for exactly one cycle, one clock after each request.
interface cache_if #(
  parameter int TAG_W = 12
);
  logic             req_valid;
  logic [2:0]       req_cmd;
  logic [31:0]      req_addr;
  logic             resp_valid;
  logic [3:0]       resp_result;
  logic [1:0]       resp_mesi;
  logic             resp_wb;
  logic [TAG_W-1:0] resp_wb_tag;

  modport master (
    output req_valid, req_cmd, req_addr,
    input  resp_valid, resp_result, resp_mesi, resp_wb, resp_wb_tag
  );

  modport slave (
    input  req_valid, req_cmd, req_addr,
    output resp_valid, resp_result, resp_mesi, resp_wb, resp_wb_tag
  );
endinterface

// File: rtl/cache_module.sv
// Set-associative MESI tag/state store with true-LRU replacement.
// Looks up, installs and updates one request per cycle; returns a registered {way, hit} result.
module cache_module #(
  parameter int TAG_W    = 12,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 6,
  parameter int WAYS     = 8
) (
  input  logic   clk,
  input  logic   rst,
  cache_if.slave bus
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef logic [WAY_W-1:0] way_t;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  localparam logic [2:0] CMD_RD   = 3'd1;
  localparam logic [2:0] CMD_WR   = 3'd2;
  localparam logic [2:0] CMD_SRD  = 3'd3;
  localparam logic [2:0] CMD_SINV = 3'd4;

  // Arrays carry no reset; a per-set init bit makes untouched sets read as reset contents.
  logic [WAYS-1:0][TAG_W-1:0] tag_mem  [SETS];
  logic [WAYS-1:0][1:0]       mesi_mem [SETS];
  logic [WAYS-1:0][WAY_W-1:0] age_mem  [SETS];
  logic [SETS-1:0]            set_init;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic               snoop_nohit;
  logic               unused_addr;

  assign req_tag     = bus.req_addr[31 -: TAG_W];
  assign req_idx     = bus.req_addr[OFFSET_W +: INDEX_W];
  assign snoop_nohit = bus.req_addr[1];
  assign unused_addr = ^bus.req_addr[OFFSET_W-1:2];

  logic [WAYS-1:0][TAG_W-1:0] cur_tag,  nxt_tag;
  logic [WAYS-1:0][1:0]       cur_mesi, nxt_mesi;
  logic [WAYS-1:0][WAY_W-1:0] cur_age,  nxt_age;

  always_comb begin
    if (set_init[req_idx]) begin
      cur_tag  = tag_mem[req_idx];
      cur_mesi = mesi_mem[req_idx];
      cur_age  = age_mem[req_idx];
    end else begin
      cur_tag  = '0;
      cur_mesi = '0;
      for (int w = 0; w < WAYS; w++) cur_age[w] = way_t'(w);
    end
  end

  logic hit;
  way_t hit_way;
  logic found_inv;
  way_t victim;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (cur_mesi[w] != MESI_I && cur_tag[w] == req_tag) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the way holding the oldest age.
  always_comb begin
    found_inv = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && cur_mesi[w] == MESI_I) begin
        found_inv = 1'b1;
        victim    = way_t'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (cur_age[w] == way_t'(WAYS - 1)) victim = way_t'(w);
      end
    end
  end

  logic             touch;
  way_t             acc_way;
  way_t             acc_age;
  way_t             res_way;
  logic             res_hit;
  logic [1:0]       res_mesi;
  logic             wb;
  logic [TAG_W-1:0] wb_tag;

  always_comb begin
    nxt_tag  = cur_tag;
    nxt_mesi = cur_mesi;
    nxt_age  = cur_age;
    touch    = 1'b0;
    acc_way  = hit_way;
    acc_age  = '0;
    res_way  = '0;
    res_hit  = hit;
    res_mesi = MESI_I;
    wb       = 1'b0;
    wb_tag   = '0;

    case (bus.req_cmd)
      CMD_RD, CMD_WR: begin
        touch = 1'b1;
        if (hit) begin
          acc_way = hit_way;
          if (bus.req_cmd == CMD_WR) nxt_mesi[hit_way] = MESI_M;
        end else begin
          acc_way          = victim;
          wb               = (cur_mesi[victim] == MESI_M);
          wb_tag           = wb ? cur_tag[victim] : '0;
          nxt_tag[victim]  = req_tag;
          if (bus.req_cmd == CMD_WR) nxt_mesi[victim] = MESI_M;
          else                       nxt_mesi[victim] = snoop_nohit ? MESI_E : MESI_S;
        end
      end
      CMD_SRD: begin
        if (hit && (cur_mesi[hit_way] == MESI_M || cur_mesi[hit_way] == MESI_E)) begin
          nxt_mesi[hit_way] = MESI_S;
          wb                = (cur_mesi[hit_way] == MESI_M);
          wb_tag            = wb ? cur_tag[hit_way] : '0;
        end
      end
      CMD_SINV: begin
        if (hit) begin
          nxt_mesi[hit_way] = MESI_I;
          wb                = (cur_mesi[hit_way] == MESI_M);
          wb_tag            = wb ? cur_tag[hit_way] : '0;
        end
      end
      default: ;
    endcase

    if (touch) begin
      res_way  = acc_way;
      res_mesi = nxt_mesi[acc_way];
      acc_age  = cur_age[acc_way];
      for (int w = 0; w < WAYS; w++) begin
        if (cur_age[w] < acc_age) nxt_age[w] = cur_age[w] + 1'b1;
      end
      nxt_age[acc_way] = '0;
    end else if (hit) begin
      res_way  = hit_way;
      res_mesi = nxt_mesi[hit_way];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.req_valid) begin
      tag_mem[req_idx]  <= nxt_tag;
      mesi_mem[req_idx] <= nxt_mesi;
      age_mem[req_idx]  <= nxt_age;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_init <= '0;
    end else if (bus.req_valid) begin
      set_init[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid  <= 1'b0;
      bus.resp_result <= 4'b0000;
      bus.resp_mesi   <= MESI_I;
      bus.resp_wb     <= 1'b0;
      bus.resp_wb_tag <= '0;
    end else begin
      bus.resp_valid <= bus.req_valid;
      if (bus.req_valid) begin
        bus.resp_result <= {res_way, res_hit};
        bus.resp_mesi   <= res_mesi;
        bus.resp_wb     <= wb;
        bus.resp_wb_tag <= wb_tag;
      end
    end
  end
endmodule

// File: tb/tb_cache_module.sv
// Directed bench for cache_module: fills, hits, MESI transitions, LRU eviction and reset.
module tb_cache_module;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] exp_q[$];

  cache_if #(.TAG_W(12)) bus ();

  cache_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input logic [11:0] tag, input logic [13:0] idx,
                                          input logic [1:0] low);
    mk_addr = {tag, idx, 4'b0000, low};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [2:0] cmd, input logic [31:0] addr);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic [3:0] result, input logic [1:0] mesi,
                             input logic wb, input logic [11:0] wb_tag);
    check({name, ".valid"},  {31'd0, bus.resp_valid}, 32'd1);
    check({name, ".result"}, {28'd0, bus.resp_result}, {28'd0, result});
    check({name, ".mesi"},   {30'd0, bus.resp_mesi}, {30'd0, mesi});
    check({name, ".wb"},     {31'd0, bus.resp_wb}, {31'd0, wb});
    if (wb) check({name, ".wb_tag"}, {20'd0, bus.resp_wb_tag}, {20'd0, wb_tag});
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 3'd0;
    bus.req_addr  = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst.valid",  {31'd0, bus.resp_valid}, 32'd0);
    check("rst.result", {28'd0, bus.resp_result}, 32'd0);
    check("rst.mesi",   {30'd0, bus.resp_mesi}, 32'd0);
    check("rst.wb",     {31'd0, bus.resp_wb}, 32'd0);
    check("rst.wb_tag", {20'd0, bus.resp_wb_tag}, 32'd0);

    // Single read miss installs in way 0 as S, then a probe hits it.
    send(3'd1, 32'h1110_0000);
    expect_resp("rd0", 4'b0000, 2'b01, 1'b0, 12'h0);
    send(3'd0, 32'h1110_0000);
    expect_resp("probe0", 4'b0001, 2'b01, 1'b0, 12'h0);
    @(posedge clk);
    #1;
    check("idle.valid",  {31'd0, bus.resp_valid}, 32'd0);
    check("idle.result", {28'd0, bus.resp_result}, 32'd1);

    // Three fills at index 0, tag 0x111 lands in way 2.
    do_reset();
    send(3'd1, mk_addr(12'h001, 14'd0, 2'b00));
    expect_resp("fill_a", 4'b0000, 2'b01, 1'b0, 12'h0);
    send(3'd1, mk_addr(12'h002, 14'd0, 2'b00));
    expect_resp("fill_b", 4'b0010, 2'b01, 1'b0, 12'h0);
    send(3'd1, mk_addr(12'h111, 14'd0, 2'b00));
    expect_resp("fill_c", 4'b0100, 2'b01, 1'b0, 12'h0);
    send(3'd0, mk_addr(12'h111, 14'd0, 2'b00));
    expect_resp("probe_w2", 4'b0101, 2'b01, 1'b0, 12'h0);
    send(3'd0, mk_addr(12'h111, 14'd1, 2'b00));
    expect_resp("probe_idx1", 4'b0000, 2'b00, 1'b0, 12'h0);

    // MESI walk: E on NOHIT fill, M on write, S with write-back on snooped read.
    send(3'd1, mk_addr(12'hABC, 14'd5, 2'b10));
    expect_resp("mesi_rd", 4'b0000, 2'b10, 1'b0, 12'h0);
    send(3'd2, mk_addr(12'hABC, 14'd5, 2'b10));
    expect_resp("mesi_wr", 4'b0001, 2'b11, 1'b0, 12'h0);
    send(3'd3, mk_addr(12'hABC, 14'd5, 2'b10));
    expect_resp("mesi_srd", 4'b0001, 2'b01, 1'b1, 12'hABC);
    send(3'd3, mk_addr(12'hABC, 14'd5, 2'b10));
    expect_resp("mesi_srd_s", 4'b0001, 2'b01, 1'b0, 12'h0);
    send(3'd4, mk_addr(12'hABC, 14'd5, 2'b10));
    expect_resp("mesi_sinv", 4'b0001, 2'b00, 1'b0, 12'h0);
    send(3'd0, mk_addr(12'hABC, 14'd5, 2'b10));
    expect_resp("mesi_gone", 4'b0000, 2'b00, 1'b0, 12'h0);
    send(3'd1, mk_addr(12'hABD, 14'd5, 2'b01));
    expect_resp("hitm_fill", 4'b0000, 2'b01, 1'b0, 12'h0);

    // Fill all 8 ways, re-touch way 0, 9th tag write evicts way 1.
    for (int i = 0; i < 8; i++) exp_q.push_back({28'd0, 3'(i), 1'b0});
    for (int i = 0; i < 8; i++) begin
      send(3'd1, mk_addr(12'h100 + 12'(i), 14'd7, 2'b10));
      check("lru_fill.result", {28'd0, bus.resp_result}, exp_q.pop_front());
      check("lru_fill.mesi", {30'd0, bus.resp_mesi}, 32'd2);
    end
    send(3'd1, mk_addr(12'h100, 14'd7, 2'b10));
    expect_resp("lru_touch", 4'b0001, 2'b10, 1'b0, 12'h0);
    send(3'd2, mk_addr(12'h200, 14'd7, 2'b10));
    expect_resp("lru_evict", 4'b0010, 2'b11, 1'b0, 12'h0);
    send(3'd0, mk_addr(12'h101, 14'd7, 2'b10));
    expect_resp("lru_evicted", 4'b0000, 2'b00, 1'b0, 12'h0);

    // Evicting a Modified line reports a write-back of its tag.
    for (int i = 0; i < 8; i++) begin
      send(3'd2, mk_addr(12'h010 + 12'(i), 14'd8, 2'b00));
      check("mfill.result", {28'd0, bus.resp_result}, {28'd0, 3'(i), 1'b0});
    end
    send(3'd1, mk_addr(12'h018, 14'd8, 2'b00));
    expect_resp("m_evict", 4'b0000, 2'b01, 1'b1, 12'h010);

    // Reset mid-stream kills the response and forgets cached lines.
    send(3'd1, mk_addr(12'h333, 14'd9, 2'b10));
    expect_resp("pre_rst", 4'b0000, 2'b10, 1'b0, 12'h0);
    rst = 1'b1;
    #1;
    check("mid_rst.valid",  {31'd0, bus.resp_valid}, 32'd0);
    check("mid_rst.result", {28'd0, bus.resp_result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(3'd0, mk_addr(12'h333, 14'd9, 2'b10));
    expect_resp("post_rst", 4'b0000, 2'b00, 1'b0, 12'h0);
    send(3'd0, mk_addr(12'h111, 14'd0, 2'b00));
    expect_resp("post_rst_b", 4'b0000, 2'b00, 1'b0, 12'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
